// File: rtl/write_back_stage.sv
// MEM/WB pipeline register with load alignment/extension, write-back source select,
// single-shot register-file write under stall/flush, and a retired-instruction counter.
module write_back_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  wb_stall,
    input  logic                  wb_flush,
    input  logic [XLEN-1:0]       read_data_from_memory,
    input  logic [XLEN-1:0]       alu_result_from_memory,
    input  logic [XLEN-1:0]       pc_plus4,
    input  logic [1:0]            wb_sel,
    input  logic [2:0]            load_funct3,
    input  logic                  reg_write_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  instret_clr,
    output logic [XLEN-1:0]       data_write_mem,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write,
    output logic                  wb_valid,
    output logic                  retire,
    output logic [CNT_W-1:0]      instret_count
);

    localparam int LB = $clog2(XLEN / 8);

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } load_f3_e;

    logic [LB-1:0]   offset;
    logic [LB-1:0]   half_off;
    logic [LB-1:0]   word_off;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     word_v;
    logic [XLEN-1:0] lw_val;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] wb_mux;

    // Misaligned low bits are simply dropped: halfword ignores bit 0, word keeps only the top lane bit.
    assign offset   = alu_result_from_memory[LB-1:0];
    assign half_off = {offset[LB-1:1], 1'b0};
    assign word_off = {offset[LB-1], {(LB-1){1'b0}}};
    assign byte_v   = 8'(read_data_from_memory >> {offset, 3'b000});
    assign half_v   = 16'(read_data_from_memory >> {half_off, 3'b000});
    assign word_v   = 32'(read_data_from_memory >> {word_off, 3'b000});
    assign lw_val   = (XLEN == 32) ? read_data_from_memory : XLEN'($signed(word_v));

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        load_ext = lw_val;
        case (load_f3_e'(load_funct3))
            F3_LB:  load_ext = XLEN'($signed(byte_v));
            F3_LBU: load_ext = XLEN'(byte_v);
            F3_LH:  load_ext = XLEN'($signed(half_v));
            F3_LHU: load_ext = XLEN'(half_v);
            F3_LD:  if (XLEN == 64) load_ext = read_data_from_memory;
            F3_LWU: if (XLEN == 64) load_ext = XLEN'(word_v);
            default: load_ext = lw_val;
        endcase
    end

    always_comb begin
        case (wb_sel)
            2'b01:   wb_mux = load_ext;
            2'b10:   wb_mux = pc_plus4;
            default: wb_mux = alu_result_from_memory;
        endcase
    end

    logic                  valid_q, valid_d;
    logic                  new_q,   new_d;
    logic                  we_q,    we_d;
    logic [XLEN-1:0]       data_q,  data_d;
    logic [REG_ADDR_W-1:0] rd_q,    rd_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    // new_q marks the first cycle of a captured instruction, so a stall cannot repeat its write.
    always_comb begin
        valid_d = valid_q;
        new_d   = 1'b0;
        we_d    = we_q;
        data_d  = data_q;
        rd_d    = rd_q;
        if (wb_flush) begin
            valid_d = 1'b0;
        end else if (!wb_stall) begin
            valid_d = in_valid;
            new_d   = in_valid;
            we_d    = reg_write_in;
            data_d  = wb_mux;
            rd_d    = rd_in;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (instret_clr) begin
            cnt_d = '0;
        end else if (new_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: data_q and rd_q are reset too, so the forwarding bus reads zero rather than X after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            valid_q <= valid_d;
            new_q   <= new_d;
            we_q    <= we_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid       = valid_q;
    assign retire         = new_q;
    assign reg_write      = new_q & we_q & (rd_q != '0);
    assign data_write_mem = data_q;
    assign rd_out         = rd_q;
    assign instret_count  = cnt_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage: a vector table for the load/mux paths plus
// hand-written stall, flush, counter-clear, async-reset and XLEN=64 / counter-wrap sequences.
module tb_write_back_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stall, wb_flush, instret_clr;

    logic        in_valid, reg_write_in;
    logic [31:0] mem_data, alu_res, pc4;
    logic [1:0]  wb_sel;
    logic [2:0]  f3;
    logic [4:0]  rd_in;
    logic [31:0] data_o;
    logic [4:0]  rd_o;
    logic        reg_write_o, wb_valid_o, retire_o;
    logic [63:0] cnt_o;

    logic        in_valid64, reg_write_in64;
    logic [63:0] mem_data64, alu_res64, pc4_64;
    logic [1:0]  wb_sel64;
    logic [2:0]  f3_64;
    logic [4:0]  rd_in64;
    logic [63:0] data64_o;
    logic [4:0]  rd64_o;
    logic        reg_write64_o, wb_valid64_o, retire64_o;
    logic [3:0]  cnt64_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_cnt;

    always #5 clk = ~clk;

    write_back_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .wb_stall(wb_stall), .wb_flush(wb_flush),
        .read_data_from_memory(mem_data), .alu_result_from_memory(alu_res), .pc_plus4(pc4),
        .wb_sel(wb_sel), .load_funct3(f3), .reg_write_in(reg_write_in), .rd_in(rd_in),
        .instret_clr(instret_clr), .data_write_mem(data_o), .rd_out(rd_o), .reg_write(reg_write_o),
        .wb_valid(wb_valid_o), .retire(retire_o), .instret_count(cnt_o)
    );

    write_back_stage #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(4)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .wb_stall(wb_stall), .wb_flush(wb_flush),
        .read_data_from_memory(mem_data64), .alu_result_from_memory(alu_res64), .pc_plus4(pc4_64),
        .wb_sel(wb_sel64), .load_funct3(f3_64), .reg_write_in(reg_write_in64), .rd_in(rd_in64),
        .instret_clr(instret_clr), .data_write_mem(data64_o), .rd_out(rd64_o),
        .reg_write(reg_write64_o), .wb_valid(wb_valid64_o), .retire(retire64_o),
        .instret_count(cnt64_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [1:0] sel, input logic [2:0] fn,
                         input logic [31:0] md, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [4:0] rd, input logic we);
        in_valid = iv; wb_sel = sel; f3 = fn; mem_data = md; alu_res = alu; pc4 = pc;
        rd_in = rd; reg_write_in = we;
    endtask

    typedef struct {
        string       name;
        logic        iv;
        logic [1:0]  sel;
        logic [2:0]  fn;
        logic [31:0] md;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_ret;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{"lb_off3",    1'b1, 2'b01, 3'b000, 32'h80FF1234, 32'h00001003, 32'h0, 5'd7, 1'b1, 1'b1, 32'hFFFFFF80, 1'b1, 1'b1};
        vecs[1]  = '{"lbu_off3",   1'b1, 2'b01, 3'b100, 32'h80FF1234, 32'h00001003, 32'h0, 5'd7, 1'b1, 1'b1, 32'h00000080, 1'b1, 1'b1};
        vecs[2]  = '{"lh_off2",    1'b1, 2'b01, 3'b001, 32'h80017FFF, 32'h00002002, 32'h0, 5'd8, 1'b1, 1'b1, 32'hFFFF8001, 1'b1, 1'b1};
        vecs[3]  = '{"lhu_off2",   1'b1, 2'b01, 3'b101, 32'h80017FFF, 32'h00002002, 32'h0, 5'd8, 1'b1, 1'b1, 32'h00008001, 1'b1, 1'b1};
        vecs[4]  = '{"lh_off3",    1'b1, 2'b01, 3'b001, 32'h80017FFF, 32'h00002003, 32'h0, 5'd8, 1'b1, 1'b1, 32'hFFFF8001, 1'b1, 1'b1};
        vecs[5]  = '{"lhu_off3",   1'b1, 2'b01, 3'b101, 32'h80017FFF, 32'h00002003, 32'h0, 5'd8, 1'b1, 1'b1, 32'h00008001, 1'b1, 1'b1};
        vecs[6]  = '{"lh_off0",    1'b1, 2'b01, 3'b001, 32'h80017FFF, 32'h00002000, 32'h0, 5'd8, 1'b1, 1'b1, 32'h00007FFF, 1'b1, 1'b1};
        vecs[7]  = '{"pc4_rd5",    1'b1, 2'b10, 3'b000, 32'h0,        32'h0000ABCD, 32'h104, 5'd5, 1'b1, 1'b1, 32'h00000104, 1'b1, 1'b1};
        vecs[8]  = '{"pc4_rd0",    1'b1, 2'b10, 3'b000, 32'h0,        32'h0000ABCD, 32'h104, 5'd0, 1'b1, 1'b1, 32'h00000104, 1'b0, 1'b1};
        vecs[9]  = '{"alu_sel00",  1'b1, 2'b00, 3'b000, 32'hFFFFFFFF, 32'h12345678, 32'h104, 5'd3, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1};
        vecs[10] = '{"alu_sel11",  1'b1, 2'b11, 3'b000, 32'hFFFFFFFF, 32'h87654321, 32'h104, 5'd4, 1'b1, 1'b1, 32'h87654321, 1'b1, 1'b1};
        vecs[11] = '{"lw",         1'b1, 2'b01, 3'b010, 32'hCAFEBABE, 32'h00000000, 32'h0, 5'd9, 1'b1, 1'b1, 32'hCAFEBABE, 1'b1, 1'b1};
        vecs[12] = '{"ld_as_lw",   1'b1, 2'b01, 3'b011, 32'h8BADF00D, 32'h00000002, 32'h0, 5'd9, 1'b1, 1'b1, 32'h8BADF00D, 1'b1, 1'b1};
        vecs[13] = '{"no_we",      1'b1, 2'b00, 3'b000, 32'h0,        32'h00000055, 32'h0, 5'd3, 1'b0, 1'b1, 32'h00000055, 1'b0, 1'b1};
        vecs[14] = '{"bubble",     1'b0, 2'b00, 3'b000, 32'h0,        32'h00000066, 32'h0, 5'd3, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};

        rst = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0; instret_clr = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        in_valid64 = 1'b0; reg_write_in64 = 1'b0; mem_data64 = '0; alu_res64 = '0;
        pc4_64 = '0; wb_sel64 = 2'b00; f3_64 = 3'b000; rd_in64 = 5'd0;
        #12;
        check("rst_data", 64'(data_o), 64'h0);
        check("rst_rd", 64'(rd_o), 64'h0);
        check("rst_we", 64'(reg_write_o), 64'h0);
        check("rst_valid", 64'(wb_valid_o), 64'h0);
        check("rst_retire", 64'(retire_o), 64'h0);
        check("rst_cnt", cnt_o, 64'h0);
        rst = 1'b1;

        exp_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].iv, vecs[i].sel, vecs[i].fn, vecs[i].md, vecs[i].alu, vecs[i].pc,
                  vecs[i].rd, vecs[i].we);
            step();
            if (vecs[i].chk_data) check({vecs[i].name, "_data"}, 64'(data_o), 64'(vecs[i].exp_data));
            if (vecs[i].chk_data) check({vecs[i].name, "_rd"}, 64'(rd_o), 64'(vecs[i].rd));
            check({vecs[i].name, "_we"}, 64'(reg_write_o), 64'(vecs[i].exp_we));
            check({vecs[i].name, "_retire"}, 64'(retire_o), 64'(vecs[i].exp_ret));
            check({vecs[i].name, "_valid"}, 64'(wb_valid_o), 64'(vecs[i].iv));
            check({vecs[i].name, "_cnt"}, cnt_o, exp_cnt);
            if (vecs[i].exp_ret) exp_cnt = exp_cnt + 1;
        end

        // Stall: one capture followed by three stalled cycles presenting different data.
        drive(1'b1, 2'b00, 3'b000, 32'h0, 32'h0000AAAA, 32'h0, 5'd9, 1'b1);
        step();
        check("stall_cap_we", 64'(reg_write_o), 64'h1);
        check("stall_cap_ret", 64'(retire_o), 64'h1);
        check("stall_cap_cnt", cnt_o, exp_cnt);
        exp_cnt = exp_cnt + 1;
        wb_stall = 1'b1;
        drive(1'b1, 2'b00, 3'b000, 32'h0, 32'h00005555, 32'h0, 5'd10, 1'b1);
        for (int s = 0; s < 3; s++) begin
            step();
            check("stall_we", 64'(reg_write_o), 64'h0);
            check("stall_ret", 64'(retire_o), 64'h0);
            check("stall_valid", 64'(wb_valid_o), 64'h1);
            check("stall_data", 64'(data_o), 64'h0000AAAA);
            check("stall_rd", 64'(rd_o), 64'd9);
            check("stall_cnt", cnt_o, exp_cnt);
        end
        wb_stall = 1'b0;
        step();
        check("unstall_data", 64'(data_o), 64'h00005555);
        check("unstall_ret", 64'(retire_o), 64'h1);
        exp_cnt = exp_cnt + 1;

        // Flush beats stall while an instruction is presented.
        wb_stall = 1'b1; wb_flush = 1'b1;
        step();
        check("flush_valid", 64'(wb_valid_o), 64'h0);
        check("flush_ret", 64'(retire_o), 64'h0);
        check("flush_we", 64'(reg_write_o), 64'h0);
        check("flush_cnt", cnt_o, exp_cnt);
        wb_stall = 1'b0; wb_flush = 1'b0;

        // Counter clear coinciding with a retire pulse.
        drive(1'b1, 2'b00, 3'b000, 32'h0, 32'h00000011, 32'h0, 5'd2, 1'b1);
        step();
        check("clr_pre_ret", 64'(retire_o), 64'h1);
        instret_clr = 1'b1;
        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        step();
        check("clr_cnt", cnt_o, 64'h0);
        instret_clr = 1'b0;
        step();
        check("clr_cnt_hold", cnt_o, 64'h0);

        // Async reset while stalled holding a live instruction.
        drive(1'b1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h00000200, 5'd6, 1'b1);
        step();
        wb_stall = 1'b1;
        step();
        check("prerst_valid", 64'(wb_valid_o), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_data", 64'(data_o), 64'h0);
        check("arst_rd", 64'(rd_o), 64'h0);
        check("arst_valid", 64'(wb_valid_o), 64'h0);
        check("arst_we", 64'(reg_write_o), 64'h0);
        check("arst_ret", 64'(retire_o), 64'h0);
        check("arst_cnt", cnt_o, 64'h0);
        wb_stall = 1'b0;
        #2;
        rst = 1'b1;
        step();
        check("postrst_data", 64'(data_o), 64'h00000200);
        check("postrst_we", 64'(reg_write_o), 64'h1);
        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        step();

        // XLEN=64 load lanes.
        mem_data64 = 64'hDEADBEEF_00000001; alu_res64 = 64'h4; wb_sel64 = 2'b01;
        rd_in64 = 5'd1; reg_write_in64 = 1'b1; in_valid64 = 1'b1;
        f3_64 = 3'b110;
        step();
        check("x64_lwu_off4", data64_o, 64'h00000000_DEADBEEF);
        f3_64 = 3'b010;
        step();
        check("x64_lw_off4", data64_o, 64'hFFFFFFFF_DEADBEEF);
        f3_64 = 3'b011;
        step();
        check("x64_ld", data64_o, 64'hDEADBEEF_00000001);
        f3_64 = 3'b000; alu_res64 = 64'h7;
        step();
        check("x64_lb_off7", data64_o, 64'hFFFFFFFF_FFFFFFDE);
        f3_64 = 3'b010; alu_res64 = 64'h0;
        step();
        check("x64_lw_off0", data64_o, 64'h00000000_00000001);

        // Counter wrap on the CNT_W=4 instance: 5 retires above plus 12 more = 17 total.
        for (int k = 0; k < 12; k++) step();
        in_valid64 = 1'b0;
        step();
        check("x64_wrap_cnt", 64'(cnt64_o), 64'h1);
        check("x64_idle_ret", 64'(retire64_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Parametrised successor to the single-mux write-back stage of the RISC-V pipeline. Registers the MEM/WB boundary, selects the write-back source, aligns and sign/zero-extends load data, and drives the register-file write port and forwarding bus. It issues exactly one write per retired instruction under stall and flush, and keeps a retired-instruction counter. It sits between the memory stage and the register file / hazard unit.

## Interface

**Parameters**
- `XLEN`, default 32: datapath width. Legal values are 32 or 64.
- `REG_ADDR_W`, default 5: register index width.
- `CNT_W`, default 64: retired-instruction counter width.

**Ports**
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  memory stage presents an instruction.
- `wb_stall`  in  1  hazard unit: hold the WB register.
- `wb_flush`  in  1  kill the instruction being captured.
- `read_data_from_memory`  in  XLEN  raw aligned memory word.
- `alu_result_from_memory`  in  XLEN  ALU result. It is also the load address, and its low bits select the byte lane.
- `pc_plus4`  in  XLEN  link value for JAL/JALR.
- `wb_sel`  in  2  source select: 00 ALU, 01 load, 10 pc_plus4, 11 ALU.
- `load_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 LD, 110 LWU.
- `reg_write_in`  in  1  instruction writes rd.
- `rd_in`  in  REG_ADDR_W  destination register.
- `instret_clr`  in  1  synchronous clear of the counter.
- `data_write_mem`  out  XLEN  register-file write data / forwarding data.
- `rd_out`  out  REG_ADDR_W  destination register.
- `reg_write`  out  1  register-file write enable.
- `wb_valid`  out  1  WB register holds a live instruction; drives forwarding.
- `retire`  out  1  one-cycle pulse per retired instruction.
- `instret_count`  out  CNT_W  retired-instruction count.

## Operation

**Load path** (combinational, computed before the register)
- Lane offset is `alu_result_from_memory[LB-1:0]`, where LB = log2(XLEN/8).
- LB / LBU: select the byte at offset×8, then sign- or zero-extend to XLEN.
- LH / LHU: select the halfword at (offset with bit 0 forced to 0)×8, then extend.
- LW: with XLEN=32, pass the word. With XLEN=64, select the word at bit 32 × offset[2], then sign-extend. LWU zero-extends.
- LD: pass the full word when XLEN=64.
- With XLEN=32, funct3 011 and 110 are treated as LW.
- Any other funct3 is treated as LW.
- Misaligned addresses are not trapped here; the low offset bits are ignored as stated above.

**Write-data mux**
- Selects from ALU, extended load, or pc_plus4 per `wb_sel`.

**WB register**
- Holds `valid_q`, `new_q`, `data_q`, `rd_q`, and `we_q`.
- Per-edge priority is flush > stall > capture.
- **Flush:** `valid_q`=0 and `new_q`=0. Data fields are don't-care.
- **Stall, no flush:** all fields hold and `new_q` is set to 0.
- **Capture:**
  - `valid_q`=`in_valid`, `new_q`=`in_valid`.
  - `data_q`=mux output, `rd_q`=`rd_in`, `we_q`=`reg_write_in`.

**Outputs**
- `wb_valid`=`valid_q`.
- `retire`=`new_q`.
- `reg_write`=`new_q` & `we_q` & (`rd_q`≠0). Writes to x0 are suppressed.
- `data_write_mem`=`data_q`.
- `rd_out`=`rd_q`.

**Counter**
- `instret_clr`=1: count becomes 0. Clear wins over a simultaneous retire.
- Otherwise `retire`=1: count+1, wrapping modulo 2^CNT_W.

## Timing

- Latency is 1 cycle: inputs at edge N appear on the outputs after edge N.
- `reg_write` and `retire` are each high for exactly one cycle per captured valid instruction, however long the stall lasts.
- `wb_valid` and `data_write_mem` remain valid while stalled, so forwarding stays correct.
- The counter reflects a retire one edge after the `retire` pulse.
- **Reset values:**
  - `valid_q`, `new_q`, and `we_q` are 0.
  - `data_q` and `rd_q` are 0, so `data_write_mem` and `rd_out` are 0.
  - `reg_write`, `retire`, and `wb_valid` are 0.
  - `instret_count` is 0.
- Reset asserted mid-stall or mid-flush returns everything to reset values immediately. The first capture occurs on the first rising edge after deassertion.
- `in_valid`=0 on capture: `valid_q`=0, with no write and no retire.

## Test plan

- **LB, offset 3:** word 0x80FF_1234, LB at address 0x...03 → `data_write_mem`=0xFFFF_FF80, `reg_write`=1 one cycle later. LBU at the same address → 0x0000_0080.
- **LH / LHU, offset 2:** word 0x8001_7FFF → LH gives 0xFFFF_8001, LHU gives 0x0000_8001. At offset 3 → same results (bit 0 ignored).
- **Source select and x0:** `wb_sel`=10, `pc_plus4`=0x104, rd=5 → data 0x104 and `reg_write`=1. Same with rd=0 → `reg_write`=0, `retire`=1.
- **Stall:** capture an instruction, then hold `wb_stall` high for 3 cycles → `reg_write` and `retire` pulse once, `wb_valid` stays 1, data is held, and the count advances by exactly 1.
- **Priority and reset:**
  - Flush and stall together with `in_valid`=1 → `wb_valid`=0, no retire.
  - `instret_clr` together with `retire` → count reads 0.
  - Assert `rst` mid-stream → all outputs go to 0 asynchronously.
- **Wrap and XLEN=64:** with `CNT_W`=4, 17 retires → count=1. With `XLEN`=64, LWU at offset 4 of 0xDEAD_BEEF_0000_0001 → 0x0000_0000_DEAD_BEEF.
